// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared core constants: opcodes, MEM command kinds, control FSM states
package pipeline_ctrl_pkg;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_OP     = 7'b0110011;
  localparam opcode_t OPC_STORE  = 7'b0100011;
  localparam opcode_t OPC_BRANCH = 7'b1100011;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;
  localparam opcode_t OPC_JAL    = 7'b1101111;
  localparam opcode_t OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] MEM_CMD_LOAD  = 2'b01;
  localparam logic [1:0] MEM_CMD_CSR   = 2'b10;
  localparam logic [1:0] MEM_CMD_STORE = 2'b11;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_FLUSH,
    S_DRAIN
  } state_t;

  function automatic logic reads_rs1(opcode_t op);
    return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  endfunction

  function automatic logic reads_rs2(opcode_t op);
    return (op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - decode/EX/MEM status in, stall/bubble controls out
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  opcode_t     id_opcode;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  ex_reg_d;
  logic [4:0]  ex_mem_command;
  logic        mem_req;
  logic        mem_ready;
  logic        redirect;
  logic        stop;
  logic        bubble;
  logic        pc_hold;
  logic [31:0] stall_cycles;

  modport master (
    output id_opcode, id_rs1_addr, id_rs2_addr, ex_reg_d, ex_mem_command,
    output mem_req, mem_ready, redirect,
    input  stop, bubble, pc_hold, stall_cycles
  );

  modport slave (
    input  id_opcode, id_rs1_addr, id_rs2_addr, ex_reg_d, ex_mem_command,
    input  mem_req, mem_ready, redirect,
    output stop, bubble, pc_hold, stall_cycles
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_cmp.sv
// rtl/pipeline_ctrl_hazard_cmp.sv - combinational load-use hazard comparator
import pipeline_ctrl_pkg::*;

module hazard_cmp (
  input  opcode_t    id_opcode,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic [4:0] ex_reg_d,
  input  logic [1:0] ex_mem_kind,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  // Only sources the decoded format actually reads can create a dependency.
  always_comb begin
    rs1_hit = reads_rs1(id_opcode) && (id_rs1_addr == ex_reg_d);
    rs2_hit = reads_rs2(id_opcode) && (id_rs2_addr == ex_reg_d);
    hazard  = (ex_mem_kind == MEM_CMD_LOAD) && (ex_reg_d != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline hazard/stall controller: mem wait, redirect flush, system drain
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus
);

  localparam cnt_t FLUSH_LOAD = cnt_t'(FLUSH_CYCLES - 1);
  localparam cnt_t DRAIN_LOAD = cnt_t'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        drained_q, drained_d, drained_live;
  logic        pend_q, pend_d;
  opcode_t     opcode_q;
  logic [31:0] stall_q;
  logic        stop, bubble, pc_hold;
  logic        hazard;
  logic        mem_stall;
  logic        unused_cmd_bits;

  assign unused_cmd_bits = ^bus.ex_mem_command[4:2];

  hazard_cmp u_hazard_cmp (
    .id_opcode   (bus.id_opcode),
    .id_rs1_addr (bus.id_rs1_addr),
    .id_rs2_addr (bus.id_rs2_addr),
    .ex_reg_d    (bus.ex_reg_d),
    .ex_mem_kind (bus.ex_mem_command[1:0]),
    .hazard      (hazard)
  );

  always_ff @(posedge clk) begin
    opcode_q <= bus.id_opcode;
    if (rst) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      drained_q <= 1'b0;
      pend_q    <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drained_q <= drained_d;
      pend_q    <= pend_d;
      if ((stop || bubble) && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    stop         = 1'b0;
    bubble       = 1'b0;
    pc_hold      = 1'b0;
    mem_stall    = bus.mem_req && !bus.mem_ready;
    drained_live = drained_q && (bus.id_opcode == opcode_q);
    drained_d    = drained_live;

    if ((state_q == S_MEM_WAIT) ? !bus.mem_ready : mem_stall) begin
      // A redirect arriving under a freeze is remembered and replayed once the freeze lifts.
      stop = 1'b1;
      if (bus.redirect) pend_d = 1'b1;
      if (state_q == S_RUN) state_d = S_MEM_WAIT;
    end else begin
      pend_d = 1'b0;
      if (bus.redirect || pend_q) begin
        bubble    = 1'b1;
        drained_d = 1'b0;
        cnt_d     = FLUSH_LOAD;
        state_d   = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
      end else begin
        case (state_q)
          S_FLUSH: begin
            bubble = 1'b1;
            cnt_d  = (cnt_q == '0) ? '0 : cnt_q - cnt_t'(1);
            if (cnt_q <= cnt_t'(1)) state_d = S_RUN;
          end
          S_DRAIN: begin
            bubble  = 1'b1;
            pc_hold = 1'b1;
            cnt_d   = (cnt_q == '0) ? '0 : cnt_q - cnt_t'(1);
            if (cnt_q <= cnt_t'(1)) begin
              state_d   = S_RUN;
              drained_d = 1'b1;
            end
          end
          default: begin
            state_d = S_RUN;
            if (hazard) begin
              bubble  = 1'b1;
              pc_hold = 1'b1;
            end else if (bus.id_opcode == OPC_SYSTEM && !drained_live) begin
              bubble  = 1'b1;
              pc_hold = 1'b1;
              cnt_d   = DRAIN_LOAD;
              if (DRAIN_CYCLES > 1) state_d = S_DRAIN;
              else                  drained_d = 1'b1;
            end
          end
        endcase
      end
    end

    if (rst) begin
      stop    = 1'b0;
      bubble  = 1'b1;
      pc_hold = 1'b1;
    end
  end

  assign bus.stop         = stop;
  assign bus.bubble       = bubble;
  assign bus.pc_hold      = pc_hold;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int FLUSH_N = 2;
  localparam int DRAIN_N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if pif ();

  pipeline_ctrl #(.FLUSH_CYCLES(FLUSH_N), .DRAIN_CYCLES(DRAIN_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  logic [6:0]  op;
  logic [4:0]  rs1, rs2, rd, cmd;
  logic        mreq, mrdy, redir, r;
  logic        o_stop, o_bub, o_pch;
  logic [31:0] o_stall;

  bit          m_wait, m_drained, m_pend;
  int          m_flush, m_drain;
  logic [6:0]  m_lastop;
  logic [31:0] m_stall;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hazard(input logic [6:0] o, input logic [4:0] a1, input logic [4:0] a2,
                                      input logic [4:0] d, input logic [4:0] c);
    bit use1, use2;
    if (c[1:0] != 2'b01 || d == 5'd0) return 1'b0;
    use2 = (o == 7'b0110011) || (o == 7'b0100011) || (o == 7'b1100011);
    use1 = !((o == 7'b0110111) || (o == 7'b0010111) || (o == 7'b1101111));
    return (use1 && a1 == d) || (use2 && a2 == d);
  endfunction

  task automatic set_idle();
    r = 0; op = 7'b0010011; rs1 = 0; rs2 = 0; rd = 0; cmd = 0;
    mreq = 0; mrdy = 0; redir = 0;
  endtask

  // One clock: drive inputs, compare outputs against the model, advance the model.
  task automatic tick();
    bit e_stop, e_bub, e_pch;
    @(negedge clk);
    rst = r;
    pif.id_opcode = op; pif.id_rs1_addr = rs1; pif.id_rs2_addr = rs2;
    pif.ex_reg_d = rd; pif.ex_mem_command = cmd;
    pif.mem_req = mreq; pif.mem_ready = mrdy; pif.redirect = redir;
    #1;
    o_stop = pif.stop; o_bub = pif.bubble; o_pch = pif.pc_hold; o_stall = pif.stall_cycles;
    e_stop = 0; e_bub = 0; e_pch = 0;
    if (r) begin
      e_bub = 1; e_pch = 1;
    end else begin
      if (op != m_lastop) m_drained = 0;
      if (m_wait ? !mrdy : (mreq && !mrdy)) begin
        e_stop = 1;
        if (redir) m_pend = 1;
        if (m_flush == 0 && m_drain == 0) m_wait = 1;
      end else begin
        m_wait = 0;
        if (redir || m_pend) begin
          e_bub = 1; m_flush = FLUSH_N - 1; m_drain = 0; m_drained = 0;
        end else if (m_flush > 0) begin
          e_bub = 1; m_flush--;
        end else if (m_drain > 0) begin
          e_bub = 1; e_pch = 1; m_drain--;
          if (m_drain == 0) m_drained = 1;
        end else if (model_hazard(op, rs1, rs2, rd, cmd)) begin
          e_bub = 1; e_pch = 1;
        end else if (op == 7'b1110011 && !m_drained) begin
          e_bub = 1; e_pch = 1; m_drain = DRAIN_N - 1;
          if (m_drain == 0) m_drained = 1;
        end
        m_pend = 0;
      end
    end
    check_val("stop", 32'(o_stop), 32'(e_stop));
    check_val("bubble", 32'(o_bub), 32'(e_bub));
    check_val("pc_hold", 32'(o_pch), 32'(e_pch));
    check_val("stall_cycles", o_stall, m_stall);
    if (r) begin
      m_wait = 0; m_flush = 0; m_drain = 0; m_drained = 0; m_pend = 0; m_stall = 0;
    end else if ((e_stop || e_bub) && m_stall != 32'hFFFF_FFFF) begin
      m_stall = m_stall + 1;
    end
    m_lastop = op;
  endtask

  logic [6:0] ops [9] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                          7'b1101111, 7'b1110011, 7'b0010011, 7'b0000011};

  initial begin
    int nb;
    logic [31:0] s0;
    m_wait = 0; m_drained = 0; m_pend = 0; m_flush = 0; m_drain = 0; m_lastop = 0; m_stall = 0;
    set_idle();
    rst = 1'b1;

    r = 1; tick(); tick();
    check_val("rst_bubble", 32'(o_bub), 32'd1);
    check_val("rst_pc_hold", 32'(o_pch), 32'd1);
    r = 0; tick();
    check_val("post_rst_stall", o_stall, 32'd0);

    // load-use
    cmd = 5'b01001; rd = 5; op = 7'b0110011; rs2 = 5; tick();
    check_val("lu_bubble", 32'(o_bub), 32'd1);
    check_val("lu_pc_hold", 32'(o_pch), 32'd1);
    cmd = 0; tick();
    check_val("lu_one_cycle", 32'(o_bub), 32'd0);
    cmd = 5'b01001; rd = 0; rs2 = 0; tick();
    check_val("lu_x0", 32'(o_bub), 32'd0);
    set_idle(); tick();

    // memory wait
    s0 = o_stall; nb = 0;
    mreq = 1; mrdy = 0; tick(); nb += o_stop;
    mreq = 0;
    repeat (3) begin tick(); nb += o_stop; end
    mrdy = 1; tick();
    check_val("mw_ready_stop", 32'(o_stop), 32'd0);
    check_val("mw_stop_cycles", 32'(nb), 32'd4);
    set_idle(); tick();
    check_val("mw_stall_delta", o_stall - s0, 32'd4);

    // redirect flush
    nb = 0;
    redir = 1; tick(); nb += o_bub;
    redir = 0; tick();
    check_val("fl_second", 32'(o_bub), 32'd1);
    nb += o_bub;
    repeat (3) begin tick(); nb += o_bub; end
    check_val("fl_count", 32'(nb), 32'(FLUSH_N));
    redir = 1; mreq = 1; mrdy = 0; tick();
    check_val("fl_mem_stop", 32'(o_stop), 32'd1);
    check_val("fl_mem_nobub", 32'(o_bub), 32'd0);
    redir = 0; mreq = 0; tick();
    mrdy = 1; tick();
    check_val("fl_resume", 32'(o_bub), 32'd1);
    mrdy = 0; tick();
    check_val("fl_resume2", 32'(o_bub), 32'd1);
    tick();
    check_val("fl_resume_done", 32'(o_bub), 32'd0);

    // system drain
    op = 7'b1110011; nb = 0;
    repeat (3) begin tick(); nb += (o_bub && o_pch); end
    check_val("dr_count", 32'(nb), 32'(DRAIN_N));
    tick();
    check_val("dr_release", 32'(o_bub), 32'd0);
    op = 7'b0010011; tick();
    op = 7'b1110011; tick();
    redir = 1; tick();
    redir = 0; op = 7'b0010011; tick();
    check_val("dr_redir_flush", 32'(o_bub), 32'd1);
    check_val("dr_redir_nohold", 32'(o_pch), 32'd0);
    tick();
    check_val("dr_redir_done", 32'(o_bub), 32'd0);

    // reset mid-flush, then saturation
    redir = 1; tick();
    redir = 0; r = 1; tick();
    r = 0; tick();
    check_val("rst_mid_bubble", 32'(o_bub), 32'd0);
    check_val("rst_mid_stall", o_stall, 32'd0);
    check_val("rst_mid_state", 32'(dut.state_q), 32'(S_RUN));
    @(posedge clk); #1;
    dut.stall_q <= 32'hFFFF_FFFE;
    m_stall = 32'hFFFF_FFFE;
    mreq = 1; mrdy = 0; tick();
    mreq = 0; tick(); tick();
    mrdy = 1; tick();
    set_idle(); tick();
    check_val("sat_stall", o_stall, 32'hFFFF_FFFF);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) op = ops[$urandom_range(0, 8)];
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      cmd = 5'($urandom);
      mreq  = ($urandom_range(0, 5) == 0);
      mrdy  = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 11) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
